i2c_regfile: RTL and testbench



---
 rtl/i2c_regfile_pkg.sv | 18 +
 rtl/i2c_regfile_if.sv | 13 +
 rtl/i2c_regfile_idx_ctr.sv | 40 ++++
 rtl/i2c_regfile.sv | 120 ++++++++++++
 tb/tb_i2c_regfile.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_regfile_pkg.sv
// Shared types and constants for the I2C register file.
// Latency: none (declarations only).
// Backpressure: none.
package i2c_pkg;

  // Transfer phase of the I2C side of the register file.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PTR_HI = 2'd1,
    ST_PTR_LO = 2'd2,
    ST_DATA   = 2'd3
  } state_t;

  // Supported I2C register-pointer lengths in bytes.
  localparam int unsigned PTR_LEN_1 = 1;
  localparam int unsigned PTR_LEN_2 = 2;

endpackage

// File: rtl/i2c_regfile_if.sv
// Strobe interface between the i2c_slave byte engine and the register file.
// Latency: none (wires only); strobes are single-cycle pulses.
// Backpressure: none; the register file must accept every strobe.
interface i2c_regfile_if;
  logic       as_in;    // address match
  logic       rs_in;    // read byte done
  logic       ws_in;    // write byte received
  logic [7:0] wdat_in;  // byte from master, valid with ws_in
  logic [7:0] rdat_out; // byte to master

  modport master (output as_in, rs_in, ws_in, wdat_in, input rdat_out);
  modport slave  (input as_in, rs_in, ws_in, wdat_in, output rdat_out);
endinterface

// File: rtl/i2c_regfile_idx_ctr.sv
// I2C register index: pointer load plus AUTO_INC/WRAP advance.
// Latency: new index visible one cycle after load_i/adv_i.
// Backpressure: none; load_i takes priority over adv_i.
module i2c_idx_ctr #(
  parameter int unsigned LD_NBYTES = 3,
  parameter int unsigned AUTO_INC  = 1,
  parameter int unsigned WRAP      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic [LD_NBYTES-1:0] load_val_i,
  input  logic                 adv_i,
  output logic [LD_NBYTES-1:0] idx_o
);

  logic [LD_NBYTES-1:0] idx_q;
  logic [LD_NBYTES-1:0] idx_d;

  // Next index: pointer load, else optional increment that wraps or saturates.
  always_comb begin
    idx_d = idx_q;
    if (load_i) begin
      idx_d = load_val_i;
    end else if (adv_i && (AUTO_INC != 0)) begin
      if ((WRAP != 0) || !(&idx_q)) begin
        idx_d = idx_q + LD_NBYTES'(1);
      end
    end
  end

  // Index register.
  always_ff @(posedge clk) begin
    if (rst) idx_q <= '0;
    else     idx_q <= idx_d;
  end

  assign idx_o = idx_q;

endmodule

// File: rtl/i2c_regfile.sv
// Register file between i2c_slave strobes and fabric; optional write protect via I2C_REGFILE_WPROT_EN.
// Latency: rdat_out combinational; h_rdata, wr_stb/wr_addr one cycle after the access.
// Backpressure: none; I2C data write beats a same-address fabric write, which is dropped.
module i2c_regfile
  import i2c_pkg::*;
#(
  parameter int unsigned LD_NBYTES = 3,
  parameter int unsigned PTR_BYTES = 1,
  parameter int unsigned AUTO_INC  = 1,
  parameter int unsigned WRAP      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  i2c_regfile_if.slave         bus,
  input  logic                 h_we,
  input  logic [LD_NBYTES-1:0] h_addr,
  input  logic [7:0]           h_wdata,
  output logic [7:0]           h_rdata,
  output logic                 wr_stb,
  output logic [LD_NBYTES-1:0] wr_addr,
`ifdef I2C_REGFILE_WPROT_EN
  input  logic                 wprot,
  output logic                 wprot_err,
`endif
  output logic [LD_NBYTES-1:0] idx_out
);

  localparam int unsigned NREG = 1 << LD_NBYTES;

  logic [7:0]           mem_q [NREG];
  state_t               state_q;
  logic [7:0]           h_rdata_q;
  logic                 wr_stb_q;
  logic [LD_NBYTES-1:0] wr_addr_q;
  logic [LD_NBYTES-1:0] idx;
  logic                 data_ws;
  logic                 wr_ok;
  logic                 blocked;
  logic                 ptr_load;
  logic                 idx_adv;
  logic                 fab_ok;

  // Decode strobes: as_in masks everything, ws_in beats rs_in.
  always_comb begin
    data_ws  = bus.ws_in && !bus.as_in && ((state_q == ST_IDLE) || (state_q == ST_DATA));
    ptr_load = bus.ws_in && !bus.as_in && (state_q == ST_PTR_LO);
    idx_adv  = !bus.as_in && (data_ws || (bus.rs_in && !bus.ws_in));
`ifdef I2C_REGFILE_WPROT_EN
    wr_ok    = data_ws && !wprot;
    blocked  = data_ws && wprot;
`else
    wr_ok    = data_ws;
    blocked  = 1'b0;
`endif
    fab_ok   = h_we && !(wr_ok && (h_addr == idx));
  end

  i2c_idx_ctr #(
    .LD_NBYTES (LD_NBYTES),
    .AUTO_INC  (AUTO_INC),
    .WRAP      (WRAP)
  ) u_idx (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ptr_load),
    .load_val_i (bus.wdat_in[LD_NBYTES-1:0]),
    .adv_i      (idx_adv),
    .idx_o      (idx)
  );

  // Transfer FSM, memory writes and registered fabric/notify outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      h_rdata_q <= '0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else begin
      h_rdata_q <= mem_q[h_addr];
      wr_stb_q  <= wr_ok;
      if (wr_ok)  wr_addr_q     <= idx;
      if (fab_ok) mem_q[h_addr] <= h_wdata;
      if (wr_ok)  mem_q[idx]    <= bus.wdat_in;
      if (bus.as_in) begin
        state_q <= (PTR_BYTES == PTR_LEN_2) ? ST_PTR_HI : ST_PTR_LO;
      end else if (bus.ws_in) begin
        case (state_q)
          ST_PTR_HI: state_q <= ST_PTR_LO;
          ST_PTR_LO: state_q <= ST_DATA;
          default:   state_q <= state_q;
        endcase
      end else if (bus.rs_in) begin
        state_q <= ST_DATA;
      end
    end
  end

`ifdef I2C_REGFILE_WPROT_EN
  logic wprot_err_q;

  // One pulse per I2C data write refused by write protect.
  always_ff @(posedge clk) begin
    if (rst) wprot_err_q <= 1'b0;
    else     wprot_err_q <= blocked;
  end

  assign wprot_err = wprot_err_q;
`else
  logic unused_blocked;
  assign unused_blocked = blocked;
`endif

  assign bus.rdat_out = mem_q[idx];
  assign h_rdata      = h_rdata_q;
  assign wr_stb       = wr_stb_q;
  assign wr_addr      = wr_addr_q;
  assign idx_out      = idx;

endmodule

// File: tb/tb_i2c_regfile.sv
// Directed bench for i2c_regfile: four instances (1-byte ptr, 2-byte ptr wrap/saturate, no auto-inc).
// All instances see the same stimulus; each scenario checks only the relevant instance.
module tb_i2c_regfile;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       rst, as_s, rs_s, ws_s, h_we, wprot;
  logic [7:0] wdat_s, h_wdata;
  logic [2:0] h_addr;

  logic [7:0] hrd   [4];
  logic [3:0] stb;
  logic [3:0] perr;
  logic [2:0] waddr [4];
  logic [2:0] idx   [4];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  i2c_regfile_if bif [4] ();

  for (genvar g = 0; g < 4; g++) begin : g_drv
    assign bif[g].as_in   = as_s;
    assign bif[g].rs_in   = rs_s;
    assign bif[g].ws_in   = ws_s;
    assign bif[g].wdat_in = wdat_s;
  end

  i2c_regfile #(.LD_NBYTES(3), .PTR_BYTES(1), .AUTO_INC(1), .WRAP(1)) dut_a (
    .clk(clk), .rst(rst), .bus(bif[0]), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_rdata(hrd[0]), .wr_stb(stb[0]), .wr_addr(waddr[0]),
`ifdef I2C_REGFILE_WPROT_EN
    .wprot(wprot), .wprot_err(perr[0]),
`endif
    .idx_out(idx[0]));

  i2c_regfile #(.LD_NBYTES(3), .PTR_BYTES(2), .AUTO_INC(1), .WRAP(1)) dut_b (
    .clk(clk), .rst(rst), .bus(bif[1]), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_rdata(hrd[1]), .wr_stb(stb[1]), .wr_addr(waddr[1]),
`ifdef I2C_REGFILE_WPROT_EN
    .wprot(wprot), .wprot_err(perr[1]),
`endif
    .idx_out(idx[1]));

  i2c_regfile #(.LD_NBYTES(3), .PTR_BYTES(2), .AUTO_INC(1), .WRAP(0)) dut_c (
    .clk(clk), .rst(rst), .bus(bif[2]), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_rdata(hrd[2]), .wr_stb(stb[2]), .wr_addr(waddr[2]),
`ifdef I2C_REGFILE_WPROT_EN
    .wprot(wprot), .wprot_err(perr[2]),
`endif
    .idx_out(idx[2]));

  i2c_regfile #(.LD_NBYTES(3), .PTR_BYTES(1), .AUTO_INC(0), .WRAP(1)) dut_d (
    .clk(clk), .rst(rst), .bus(bif[3]), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_rdata(hrd[3]), .wr_stb(stb[3]), .wr_addr(waddr[3]),
`ifdef I2C_REGFILE_WPROT_EN
    .wprot(wprot), .wprot_err(perr[3]),
`endif
    .idx_out(idx[3]));

`ifndef I2C_REGFILE_WPROT_EN
  assign perr = 4'b0000;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // All stimulus changes at negedge; outputs are sampled at the following negedge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_rst();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic p_as();
    as_s = 1'b1;
    tick();
    as_s = 1'b0;
  endtask

  task automatic p_rs();
    rs_s = 1'b1;
    tick();
    rs_s = 1'b0;
  endtask

  task automatic p_ws(input logic [7:0] b);
    ws_s   = 1'b1;
    wdat_s = b;
    tick();
    ws_s   = 1'b0;
  endtask

  task automatic fab_wr(input logic [2:0] a, input logic [7:0] d);
    h_we    = 1'b1;
    h_addr  = a;
    h_wdata = d;
    tick();
    h_we    = 1'b0;
  endtask

  task automatic fab_rd(input int k, input logic [2:0] a, input string tag, input logic [7:0] exp);
    h_addr = a;
    tick();
    chk(tag, hrd[k], exp);
  endtask

  initial begin
    rst = 1'b0; as_s = 1'b0; rs_s = 1'b0; ws_s = 1'b0; h_we = 1'b0; wprot = 1'b0;
    wdat_s = 8'h00; h_wdata = 8'h00; h_addr = 3'd0;
    tick();
    do_rst();

    // Reset state
    chk("rst idx", idx[0], 0);
    chk("rst rdat", bif[0].rdat_out, 8'h00);
    chk("rst wr_stb", stb[0], 0);
    chk("rst wr_addr", waddr[0], 0);
    chk("rst h_rdata", hrd[0], 8'h00);
    chk("rst state", dut_a.state_q, ST_IDLE);

    // 1-byte pointer, auto-increment write burst
    p_as();
    p_ws(8'h05);
    chk("t1 ptr no stb", stb[0], 0);
    chk("t1 ptr idx", idx[0], 5);
    p_ws(8'hAA);
    chk("t1 stb0", stb[0], 1);
    chk("t1 addr0", waddr[0], 5);
    p_ws(8'hBB);
    chk("t1 stb1", stb[0], 1);
    chk("t1 addr1", waddr[0], 6);
    chk("t1 idx end", idx[0], 7);
    tick();
    chk("t1 stb low", stb[0], 0);
    fab_rd(0, 3'd5, "t1 mem5", 8'hAA);
    fab_rd(0, 3'd6, "t1 mem6", 8'hBB);
    p_as();
    p_ws(8'h06);
    chk("t1 rdat mem6", bif[0].rdat_out, 8'hBB);

    // 2-byte pointer, high byte discarded, reads wrap/saturate
    do_rst();
    fab_wr(3'd6, 8'h66);
    fab_wr(3'd7, 8'h77);
    p_as();
    p_ws(8'h12);
    chk("t2 hi no load", idx[1], 0);
    p_ws(8'h0E);
    chk("t2 ptr no stb", stb[1], 0);
    chk("t2 idx b", idx[1], 6);
    chk("t2 rdat b6", bif[1].rdat_out, 8'h66);
    p_rs();
    chk("t2 idx c7", idx[2], 7);
    chk("t2 rdat b7", bif[1].rdat_out, 8'h77);
    p_rs();
    chk("t2 wrap idx", idx[1], 0);
    chk("t2 wrap rdat", bif[1].rdat_out, 8'h00);
    chk("t2 sat idx", idx[2], 7);
    chk("t2 sat rdat", bif[2].rdat_out, 8'h77);

    // No auto-increment
    do_rst();
    p_as();
    p_ws(8'h03);
    p_ws(8'h11);
    chk("t3 stb0", stb[3], 1);
    chk("t3 addr0", waddr[3], 3);
    p_ws(8'h22);
    chk("t3 stb1", stb[3], 1);
    chk("t3 addr1", waddr[3], 3);
    chk("t3 idx", idx[3], 3);
    chk("t3 rdat", bif[3].rdat_out, 8'h22);

    // Same-address collision: I2C wins
    do_rst();
    p_as();
    p_ws(8'h04);
    h_we = 1'b1; h_addr = 3'd4; h_wdata = 8'h55; ws_s = 1'b1; wdat_s = 8'h66;
    tick();
    h_we = 1'b0; ws_s = 1'b0;
    chk("t4 col stb", stb[0], 1);
    fab_rd(0, 3'd4, "t4 same mem4", 8'h66);

    // Different-address collision: both land
    do_rst();
    p_as();
    p_ws(8'h04);
    h_we = 1'b1; h_addr = 3'd2; h_wdata = 8'h55; ws_s = 1'b1; wdat_s = 8'h66;
    tick();
    h_we = 1'b0; ws_s = 1'b0;
    fab_rd(0, 3'd2, "t4 diff mem2", 8'h55);
    fab_rd(0, 3'd4, "t4 diff mem4", 8'h66);
    fab_wr(3'd2, 8'h5A);
    chk("t4 rbw", hrd[0], 8'h55);
    fab_rd(0, 3'd2, "t4 after wr", 8'h5A);

    // rs cancels pointer phase; reset mid-transfer
    do_rst();
    p_as();
    p_rs();
    chk("t5 rs idx", idx[0], 1);
    p_ws(8'h77);
    chk("t5 data stb", stb[0], 1);
    chk("t5 data addr", waddr[0], 1);
    chk("t5 idx", idx[0], 2);
    fab_rd(0, 3'd1, "t5 mem1", 8'h77);
    p_as();
    do_rst();
    chk("t5 rst state", dut_a.state_q, ST_IDLE);
    chk("t5 rst idx", idx[0], 0);
    fab_rd(0, 3'd1, "t5 rst mem1", 8'h00);
    p_ws(8'h33);
    chk("t5 idle stb", stb[0], 1);
    chk("t5 idle addr", waddr[0], 0);
    fab_rd(0, 3'd0, "t5 idle mem0", 8'h33);

`ifdef I2C_REGFILE_WPROT_EN
    // Write protect: pointer loads and idx advance still happen
    do_rst();
    wprot = 1'b1;
    p_as();
    p_ws(8'h02);
    chk("t6 ptr err", perr[0], 0);
    p_ws(8'h99);
    chk("t6 err", perr[0], 1);
    chk("t6 no stb", stb[0], 0);
    chk("t6 idx", idx[0], 3);
    tick();
    chk("t6 err low", perr[0], 0);
    fab_rd(0, 3'd2, "t6 mem2", 8'h00);
    wprot = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
